// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative MULTU/DIVU unit: runs a fixed iteration
// count, commits HI/LO, and stalls the front of the pipeline only on hazards.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_kind,
  input  logic             div_zero,
  input  logic             hilo_read,
  output logic             unit_start,
  output logic [1:0]       unit_op,
  output logic             busy,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             hilo_we,
  output logic             div_err,
  output logic             en_pipe
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d;

  logic             accept;
  logic [CNT_W-1:0] lastCnt;

  assign accept  = op_valid & ((op_kind == OP_MULTU) | (op_kind == OP_DIVU));
  assign lastCnt = (op_q == OP_DIVU) ? DIV_LAST : MUL_LAST;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // A divide by zero skips the iterations but still commits HI/LO via DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = err_q;
    unit_start = 1'b0;
    hilo_we    = 1'b0;
    case (state_q)
      IDLE: begin
        unit_start = accept;
        if (accept) begin
          op_d = op_kind;
          if ((op_kind == OP_DIVU) && div_zero) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (cnt_q == lastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        hilo_we = 1'b1;
        state_d = IDLE;
        op_d    = OP_NONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        op_d    = OP_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Readers in DONE must stall too: HI/LO is only written at the end of DONE.
  assign busy     = (state_q != IDLE);
  assign en_pipe  = ~(busy & (accept | hilo_read));
  assign unit_op  = op_q;
  assign iter_cnt = cnt_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios plus random traffic, checked every
// cycle against a latency-based model of the sequencer.
module tb_muldiv_ctrl;

  localparam int MULC = 32;
  localparam int DIVC = 24;
  localparam int CW   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_kind = 2'b00;
  logic          div_zero = 1'b0;
  logic          hilo_read = 1'b0;
  logic          unit_start;
  logic [1:0]    unit_op;
  logic          busy;
  logic [CW-1:0] iter_cnt;
  logic          hilo_we;
  logic          div_err;
  logic          en_pipe;

  int checks = 0;
  int errors = 0;

  // Model: an accepted op is tracked by kind and cycles elapsed since accept.
  bit       mActive = 1'b0;
  bit       mDz = 1'b0;
  bit       mErr = 1'b0;
  bit [1:0] mKind = 2'b00;
  int       mElapsed = 0;

  bit obsStart, obsBusy, obsWe, obsEn, obsErr;
  int obsIter;

  muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind),
    .div_zero(div_zero), .hilo_read(hilo_read), .unit_start(unit_start),
    .unit_op(unit_op), .busy(busy), .iter_cnt(iter_cnt), .hilo_we(hilo_we),
    .div_err(div_err), .en_pipe(en_pipe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int modelLimit();
    return (mKind == 2'b10) ? DIVC : MULC;
  endfunction

  task automatic compareAll();
    bit acc, eDone;
    int lim, eIter;
    acc   = op_valid && (op_kind == 2'b01 || op_kind == 2'b10);
    lim   = modelLimit();
    eDone = mActive && (mDz ? 1'b1 : (mElapsed == lim));
    if (!mActive || mDz) eIter = 0;
    else eIter = (mElapsed < lim) ? mElapsed : lim - 1;
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("unit_op", 32'(unit_op), mActive ? 32'(mKind) : 32'd0);
    checkOutput("iter_cnt", 32'(iter_cnt), 32'(eIter));
    checkOutput("hilo_we", 32'(hilo_we), 32'(eDone));
    checkOutput("div_err", 32'(div_err), 32'(mErr));
    checkOutput("en_pipe", 32'(en_pipe), 32'(!(mActive && (acc || hilo_read))));
    checkOutput("unit_start", 32'(unit_start), 32'(!mActive && acc));
    obsStart = unit_start;
    obsBusy  = busy;
    obsWe    = hilo_we;
    obsEn    = en_pipe;
    obsErr   = div_err;
    obsIter  = int'(iter_cnt);
  endtask

  task automatic modelStep();
    bit acc;
    acc = op_valid && (op_kind == 2'b01 || op_kind == 2'b10);
    if (!rst) begin
      mActive = 1'b0; mErr = 1'b0; mKind = 2'b00; mElapsed = 0; mDz = 1'b0;
    end else if (mActive) begin
      if ((mDz && mElapsed == 0) || (!mDz && mElapsed == modelLimit())) mActive = 1'b0;
      else mElapsed++;
    end else if (acc) begin
      mActive = 1'b1; mKind = op_kind; mDz = (op_kind == 2'b10) && div_zero;
      mErr = mDz; mElapsed = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] k, input bit dz, input bit rd);
    @(negedge clk);
    rst = r; op_valid = v; op_kind = k; div_zero = dz; hilo_read = rd;
    #1;
    compareAll();
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    int busyCnt, weCnt, stallCnt, secondStart;
    repeat (2) applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("start_after_reset", 32'(obsStart), 32'd1);

    busyCnt = 0; weCnt = 0;
    repeat (MULC + 5) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
      busyCnt += int'(obsBusy);
      weCnt   += int'(obsWe);
    end
    checkOutput("mul_busy_len", 32'(busyCnt), 32'(MULC + 1));
    checkOutput("mul_we_pulses", 32'(weCnt), 32'd1);

    // MULTU, then an MFHI held from the third cycle after accept.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    stallCnt = 0;
    repeat (MULC + 2) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      stallCnt += int'(!obsEn);
    end
    checkOutput("mfhi_stall_len", 32'(stallCnt), 32'(MULC - 1));
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    secondStart = -1;
    for (int i = 0; i < DIVC + 6; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
      if (i > 0 && obsStart && secondStart < 0) secondStart = i;
    end
    checkOutput("div_second_start", 32'(secondStart), 32'(DIVC + 2));
    repeat (DIVC + 4) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("div_err_sticky", 32'(obsErr), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("div_err_cleared", 32'(obsErr), 32'd0);
    repeat (MULC + 2) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("iter_at_reset", 32'(obsIter), 32'd10);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("busy_after_reset", 32'(obsBusy), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("kind11_no_stall", 32'(obsEn), 32'd1);
    repeat (MULC) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

    repeat (3000) begin
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0,
                    2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
